// File: rtl/vec_mul_pkg.sv
// Shared definitions for the vector-multiply result path.
//   PS_BW_DEFAULT       : default bits per result lane
//   MATRIX_SIZE_DEFAULT : default lanes per result word
//   drain_state_t       : result drain controller states (IDLE, READ, FLUSH)
package vec_mul_pkg;

  localparam int PS_BW_DEFAULT       = 20;
  localparam int MATRIX_SIZE_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

endpackage

// File: rtl/result_skid_buf.sv
// Two-entry FIFO holding result words returned by the SRAM until the
// downstream stream accepts them.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the buffer)
//   push, data : write data into the tail (caller never pushes when full)
//   pop        : drop the head entry (caller never pops when empty)
//   head       : oldest entry, zero after reset
//   occupancy  : number of stored entries, 0..2
// A simultaneous push and pop leaves occupancy unchanged; the two pointers
// address different slots whenever occupancy is 1, so order is preserved.
module result_skid_buf #(
  parameter int W = 160
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] head,
  output logic [1:0]   occupancy
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= data;
        else        slot0 <= data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head      = rd_ptr ? slot1 : slot0;
  assign occupancy = count;

endmodule

// File: rtl/result_drain_ctrl.sv
// Drains a block of result words from the result SRAM and streams them out.
// A start pulse (while not busy) samples base_addr and len; len reads are
// issued to base_addr+k (wrapping at 2^ADDRESSSIZE), returned words pass
// through a 2-entry FIFO and leave on the out_* stream in address order.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   start, base_addr, len     : drain request (len 0..15)
//   sram_rd_en, sram_result_address, sram_result_data_out
//                             : SRAM read port, data one cycle after rd_en
//   out_valid, out_ready, out_data, out_last
//                             : result stream, lane 0 in LSBs
//   busy, done                : status; done pulses the cycle after the last
//                               word is accepted, busy covers that cycle too
//   state                     : current FSM state, for observation
// Stream handshake: a word moves when out_valid & out_ready are both high at
// a rising edge; once out_valid is raised, out_valid, out_data and out_last
// hold until that transfer happens.
// Build option: define RESULT_RELU_EN to clamp negative lanes of out_data
// to zero; otherwise out_data is the stored SRAM word bit-exact.
module result_drain_ctrl
  import vec_mul_pkg::*;
#(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = PS_BW_DEFAULT,
  parameter int MATRIX_SIZE    = MATRIX_SIZE_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ADDRESSSIZE-1:0]                base_addr,
  input  logic [3:0]                            len,
  output logic                                  sram_rd_en,
  output logic [ADDRESSSIZE-1:0]                sram_result_address,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_result_data_out,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] out_data,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done,
  output drain_state_t                          state
);

  localparam int W = PARTIAL_SUM_BW * MATRIX_SIZE;

  drain_state_t           state_q;
  logic [ADDRESSSIZE-1:0] base_q;
  logic [ADDRESSSIZE-1:0] last_addr_q;
  logic [3:0]             len_q;
  logic [3:0]             rd_cnt_q;
  logic [3:0]             out_cnt_q;
  logic                   in_flight_q;
  logic                   done_q;

  logic [1:0]             occ;
  logic [W-1:0]           head;
  logic                   pop;
  logic                   rd_issue;
  logic [2:0]             budget;
  logic [ADDRESSSIZE-1:0] rd_addr;

  result_skid_buf #(.W(W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight_q),
    .pop       (pop),
    .data      (sram_result_data_out),
    .head      (head),
    .occupancy (occ)
  );

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_last  = out_valid & (out_cnt_q == len_q - 4'd1);

  // Slots committed for the next edge: stored words minus the one leaving
  // now, plus the read whose data is on the bus now. Counting the departing
  // word as free is what lets a read go out every cycle with only two slots.
  assign budget   = {1'b0, occ} + {2'b00, in_flight_q} - {2'b00, pop};
  assign rd_issue = (state_q == READ) && !rst && (budget < 3'd2);
  assign rd_addr  = base_q + ADDRESSSIZE'(rd_cnt_q);

  assign sram_rd_en          = rd_issue;
  assign sram_result_address = (state_q == READ) ? rd_addr : last_addr_q;

  assign busy  = (state_q != IDLE) || done_q;
  assign done  = done_q;
  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      last_addr_q <= '0;
      len_q       <= 4'd0;
      rd_cnt_q    <= 4'd0;
      out_cnt_q   <= 4'd0;
      in_flight_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      in_flight_q <= rd_issue;
      if (rd_issue) begin
        last_addr_q <= rd_addr;
        rd_cnt_q    <= rd_cnt_q + 4'd1;
      end
      if (pop) out_cnt_q <= out_cnt_q + 4'd1;

      case (state_q)
        IDLE: begin
          // done_q high means we are still in the busy done cycle.
          if (start && !done_q) begin
            base_q    <= base_addr;
            len_q     <= len;
            rd_cnt_q  <= 4'd0;
            out_cnt_q <= 4'd0;
            if (len == 4'd0) done_q  <= 1'b1;
            else             state_q <= READ;
          end
        end
        READ: begin
          if (rd_issue && (rd_cnt_q == len_q - 4'd1)) state_q <= FLUSH;
        end
        FLUSH: begin
          if (pop && out_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RESULT_RELU_EN
  always_comb begin
    out_data = head;
    for (int i = 0; i < MATRIX_SIZE; i++) begin
      if (head[i*PARTIAL_SUM_BW + PARTIAL_SUM_BW - 1]) out_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = '0;
    end
  end
`else
  assign out_data = head;
`endif

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Self-checking bench for result_drain_ctrl. A behavioural model holds the
// expected read addresses and stream words of the current drain in queues
// built from base_addr/len and a bench-side SRAM image.
module tb_result_drain_ctrl;
  import vec_mul_pkg::*;

  localparam int AW     = 10;
  localparam int PSW    = 20;
  localparam int MS     = 8;
  localparam int W      = PSW * MS;
  localparam int BUDGET = 200;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [3:0]    len;
  logic          sram_rd_en;
  logic [AW-1:0] sram_result_address;
  logic [W-1:0]  sram_result_data_out;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  drain_state_t  state;

  result_drain_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .base_addr            (base_addr),
    .len                  (len),
    .sram_rd_en           (sram_rd_en),
    .sram_result_address  (sram_result_address),
    .sram_result_data_out (sram_result_data_out),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_last             (out_last),
    .busy                 (busy),
    .done                 (done),
    .state                (state)
  );

  // reference model state
  logic [W-1:0]  mem [1024];
  logic [AW-1:0] exp_addr_q[$];
  logic [W-1:0]  exp_q[$];
  int            checks, errors, cyc, guard;
  int            xfer_count, start_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc;
  int            outstanding;
  bit            pend_rd, done_due, model_busy, prev_stall, prev_last, check_zero;
  logic [AW-1:0] pend_addr;
  logic [W-1:0]  prev_data, last_word;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] model_word(input logic [W-1:0] raw);
    logic [W-1:0] r;
    r = raw;
`ifdef RESULT_RELU_EN
    for (int i = 0; i < MS; i++) if (raw[i*PSW + PSW - 1]) r[i*PSW +: PSW] = '0;
`endif
    return r;
  endfunction

  function automatic logic ready_for(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (i % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // one clock cycle: respond as SRAM, check outputs, advance the model
  task automatic tick();
    logic         xfer;
    logic         start_acc;
    logic         nxt_done_due;
    logic         nxt_busy;
    logic [W-1:0] w;
    sram_result_data_out = pend_rd ? mem[pend_addr] : rand_word();
    #1;
    if (rst) begin
      exp_addr_q.delete();
      exp_q.delete();
      pend_rd     = 1'b0;
      outstanding = 0;
      done_due    = 1'b0;
      model_busy  = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      if (check_zero) begin
        check("rst_rd_en", sram_rd_en, 0);
        check("rst_addr", sram_result_address, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", state, IDLE);
        check_zero = 1'b0;
      end
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      check("busy", busy, model_busy);
      check("done", done, done_due);
      if (exp_addr_q.size() == 0) check("rd_en_idle", sram_rd_en, 0);
      else if (sram_rd_en) check("rd_addr", sram_result_address, exp_addr_q.pop_front());
      if (exp_q.size() == 0) check("valid_idle", out_valid, 0);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

      xfer = out_valid && out_ready;
      nxt_done_due = 1'b0;
      if (xfer && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("data", out_data, w);
        check("last", out_last, exp_q.size() == 0);
        last_word = out_data;
        xfer_count++;
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        if (exp_q.size() == 0) nxt_done_due = 1'b1;
      end

      start_acc = start && !model_busy;
      if (start_acc) begin
        start_cyc = cyc;
        for (int k = 0; k < int'(len); k++) begin
          logic [AW-1:0] a;
          a = AW'((int'(base_addr) + k) % 1024);
          exp_addr_q.push_back(a);
          exp_q.push_back(model_word(mem[a]));
        end
        if (len == 4'd0) nxt_done_due = 1'b1;
      end
      nxt_busy = start_acc ? 1'b1 : (done_due ? 1'b0 : model_busy);

      outstanding = outstanding + int'(sram_rd_en) - int'(xfer);
      check("outstanding_le2", outstanding <= 2, 1);

      pend_rd    = sram_rd_en;
      pend_addr  = sram_result_address;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      done_due   = nxt_done_due;
      model_busy = nxt_busy;
    end
    cyc++;
    @(negedge clk);
  endtask

  // driver: one full drain with the given ready pattern
  // mode 0: ready held high, 1: ready toggles 1/0, 2: random ready
  task automatic run_drain(input logic [AW-1:0] b, input logic [3:0] n, input int mode);
    xfer_count      = 0;
    first_valid_cyc = -1;
    first_xfer_cyc  = -1;
    last_xfer_cyc   = -1;
    start     = 1'b1;
    base_addr = b;
    len       = n;
    out_ready = ready_for(mode, 0);
    tick();
    start     = 1'b0;
    base_addr = AW'($urandom);
    len       = 4'($urandom);
    guard = 0;
    while (model_busy && guard < BUDGET) begin
      out_ready = ready_for(mode, guard + 1);
      tick();
      guard++;
    end
    check("drain_bounded", guard < BUDGET, 1);
    out_ready = 1'($urandom_range(0, 1));
    tick();
    check("word_count", xfer_count, n);
    if (n != 4'd0) check("first_valid_lat", (first_valid_cyc - start_cyc) >= 2, 1);
    if (mode == 0 && n != 4'd0) check("back_to_back", last_xfer_cyc - first_xfer_cyc, int'(n) - 1);
  endtask

  initial begin
    logic [PSW-1:0] exp_lane0;
    for (int i = 0; i < 1024; i++) mem[i] = rand_word();
    mem[100][0*PSW +: PSW] = 20'hFFFF6;
    mem[100][1*PSW +: PSW] = 20'h0000A;

    checks = 0; errors = 0; cyc = 0; outstanding = 0;
    pend_rd = 0; done_due = 0; model_busy = 0; prev_stall = 0; check_zero = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = 4'd0; out_ready = 1'b0;
    sram_result_data_out = '0;

    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check_zero = 1'b1;
    tick();

    run_drain(10'd0, 4'd8, 0);
    run_drain(AW'($urandom), 4'd4, 1);
    run_drain(10'd1022, 4'd4, 2);
    run_drain(AW'($urandom), 4'd0, 2);

    // reset in the middle of a drain, after the third word
    xfer_count = 0;
    first_valid_cyc = -1;
    first_xfer_cyc  = -1;
    start = 1'b1; base_addr = 10'd300; len = 4'd8; out_ready = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (xfer_count < 3 && guard < BUDGET) begin
      tick();
      guard++;
    end
    check("pre_rst_words", xfer_count, 3);
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    check_zero = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    run_drain(10'd300, 4'd8, 0);

    // lane clamp: lane 0 holds -10, lane 1 holds +10
    run_drain(10'd100, 4'd1, 2);
`ifdef RESULT_RELU_EN
    exp_lane0 = 20'h00000;
`else
    exp_lane0 = 20'hFFFF6;
`endif
    check("lane0_neg", last_word[0*PSW +: PSW], exp_lane0);
    check("lane1_pos", last_word[1*PSW +: PSW], 20'h0000A);

    repeat (8) run_drain(AW'($urandom), 4'($urandom_range(1, 15)), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
